// File: rtl/pc_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit_pkg
// Description : Shared types and constants for the PC / branch-resolution
//               unit. Holds the control FSM state encoding, the RV32
//               conditional-branch funct3 codes and the sequential PC step.
// Revision    : 1.0  initial release
// ============================================================================
package pc_branch_unit_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } pcu_state_e;

    // RV32 conditional branch funct3 encodings
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Byte distance to the next sequential instruction
    localparam int unsigned PC_STEP = 4;

endpackage
`default_nettype wire

// File: rtl/pc_branch_unit_compare.sv
`default_nettype none
// ============================================================================
// Module      : branch_compare
// Description : Purely combinational RV32 branch-condition evaluator.
//   Ports:
//     rs1_data  in  XLEN  register operand 1
//     rs2_data  in  XLEN  register operand 2
//     br_funct3 in  3     branch type (RV32 funct3 encoding)
//     cond_true out 1     branch condition holds
//   funct3 codes 010/011 are not branches in RV32; they evaluate false.
// Revision    : 1.0  initial release
// ============================================================================
module branch_compare #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [2:0]      br_funct3,
    output logic            cond_true
);
    import pc_branch_unit_pkg::*;

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (rs1_data == rs2_data);
    assign w_lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign w_lt_u = (rs1_data < rs2_data);

    always_comb begin
        cond_true = 1'b0;
        case (br_funct3)
            BR_EQ:   cond_true = w_eq;
            BR_NE:   cond_true = !w_eq;
            BR_LT:   cond_true = w_lt_s;
            BR_GE:   cond_true = !w_lt_s;
            BR_LTU:  cond_true = w_lt_u;
            BR_GEU:  cond_true = !w_lt_u;
            default: cond_true = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Program counter and branch-resolution unit. Owns the PC
//               register and the instruction fetch request, resolves the six
//               RV32 conditional branches plus JAL/JALR, and keeps saturating
//               branch statistics counters.
//   Ports:
//     clk, rst       clock / synchronous active-high reset
//     stall          freezes the unit for the cycle (no accept, no commit)
//     imem_ready     instruction memory accepts the request at pc
//     instr_valid    decoded instruction ready for resolution
//     br_en/br_funct3/jal_en/jalr_en   instruction class and branch type
//     rs1_data/rs2_data/imm            operands and sign-extended immediate
//     pc             current PC
//     imem_req       fetch request valid (FETCH state)
//     taken          one-cycle pulse on a committed redirect
//     link_valid     one-cycle pulse, link_addr valid for rd write
//     link_addr      pc+4 of the last committed JAL/JALR
//     trap           misaligned redirect target; sticky until reset
//     br_count       committed conditional branches (saturating)
//     taken_count    committed taken conditional branches (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module pc_branch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 imem_ready,
    input  logic                 instr_valid,
    input  logic                 br_en,
    input  logic [2:0]           br_funct3,
    input  logic                 jal_en,
    input  logic                 jalr_en,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    output logic [XLEN-1:0]      pc,
    output logic                 imem_req,
    output logic                 taken,
    output logic                 link_valid,
    output logic [XLEN-1:0]      link_addr,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] taken_count
);
    import pc_branch_unit_pkg::*;

    localparam logic [XLEN-1:0]      c_pc_step   = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0]      c_jalr_mask = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pcu_state_e           state_q,       state_d;
    logic [XLEN-1:0]      pc_q,          pc_d;
    logic                 taken_q,       taken_d;
    logic                 link_valid_q,  link_valid_d;
    logic [XLEN-1:0]      link_addr_q,   link_addr_d;
    logic [CNT_WIDTH-1:0] br_count_q,    br_count_d;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

    // ------------------------------------------------------------------
    // Resolution datapath
    // ------------------------------------------------------------------
    logic            w_cond_true;
    logic            w_is_jalr;
    logic            w_is_jal;
    logic            w_is_br;
    logic            w_br_taken;
    logic            w_redirect;
    logic            w_misaligned;
    logic            w_commit;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_rel_pc;
    logic [XLEN-1:0] w_jalr_pc;
    logic [XLEN-1:0] w_target;

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .br_funct3 (br_funct3),
        .cond_true (w_cond_true)
    );

    // Instruction class with priority jalr > jal > br
    assign w_is_jalr  = jalr_en;
    assign w_is_jal   = !jalr_en && jal_en;
    assign w_is_br    = !jalr_en && !jal_en && br_en;
    assign w_br_taken = w_is_br && w_cond_true;
    assign w_redirect = w_is_jalr || w_is_jal || w_br_taken;

    // All sums wrap modulo 2^XLEN
    assign w_seq_pc   = pc_q + c_pc_step;
    assign w_rel_pc   = pc_q + imm;
    assign w_jalr_pc  = (rs1_data + imm) & c_jalr_mask;

    always_comb begin
        w_target = w_seq_pc;
        if (w_is_jalr) begin
            w_target = w_jalr_pc;
        end else if (w_is_jal || w_br_taken) begin
            w_target = w_rel_pc;
        end
    end

    // Only redirects can land off a word boundary; the sequential path is
    // aligned as long as the PC itself is.
    assign w_misaligned = w_redirect && (w_target[1:0] != 2'b00);
    assign w_commit     = (state_q == EXEC) && instr_valid && !stall;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        taken_d       = 1'b0;
        link_valid_d  = 1'b0;
        link_addr_d   = link_addr_q;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (imem_ready && !stall) begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (w_commit) begin
                    if (w_misaligned) begin
                        // A trapping instruction is abandoned: nothing
                        // architectural changes, including the statistics.
                        state_d = TRAP;
                    end else begin
                        state_d = FETCH;
                        pc_d    = w_target;
                        taken_d = w_redirect;
                        if (w_is_jal || w_is_jalr) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = w_seq_pc;
                        end
                        if (w_is_br && (br_count_q != c_cnt_max)) begin
                            br_count_d = br_count_q + c_cnt_one;
                        end
                        if (w_br_taken && (taken_count_q != c_cnt_max)) begin
                            taken_count_d = taken_count_q + c_cnt_one;
                        end
                    end
                end
            end

            TRAP: begin
                state_d = TRAP;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            taken_q       <= 1'b0;
            link_valid_q  <= 1'b0;
            link_addr_q   <= '0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            taken_q       <= taken_d;
            link_valid_q  <= link_valid_d;
            link_addr_q   <= link_addr_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign imem_req    = (state_q == FETCH);
    assign trap        = (state_q == TRAP);
    assign taken       = taken_q;
    assign link_valid  = link_valid_q;
    assign link_addr   = link_addr_q;
    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Self-checking bench for pc_branch_unit. A default-width
//               instance and a CNT_WIDTH=4 instance share all stimulus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_ready;
    logic        instr_valid;
    logic        br_en;
    logic [2:0]  br_funct3;
    logic        jal_en;
    logic        jalr_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;

    logic [31:0] pc,        pc4;
    logic        imem_req,  imem_req4;
    logic        taken,     taken4;
    logic        link_valid, link_valid4;
    logic [31:0] link_addr, link_addr4;
    logic        trap,      trap4;
    logic [31:0] br_count,  taken_count;
    logic [3:0]  br_count4, taken_count4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_branch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .br_en(br_en), .br_funct3(br_funct3),
        .jal_en(jal_en), .jalr_en(jalr_en), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .pc(pc), .imem_req(imem_req),
        .taken(taken), .link_valid(link_valid), .link_addr(link_addr),
        .trap(trap), .br_count(br_count), .taken_count(taken_count)
    );

    pc_branch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .br_en(br_en), .br_funct3(br_funct3),
        .jal_en(jal_en), .jalr_en(jalr_en), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .pc(pc4), .imem_req(imem_req4),
        .taken(taken4), .link_valid(link_valid4), .link_addr(link_addr4),
        .trap(trap4), .br_count(br_count4), .taken_count(taken_count4)
    );

    typedef struct {
        logic        br;
        logic [2:0]  f3;
        logic        jal;
        logic        jalr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic        exp_lv;
        logic [31:0] exp_link;
        logic        exp_trap;
        logic [31:0] exp_brc;
        logic [31:0] exp_tkc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic br, input logic [2:0] f3,
                                input logic jal, input logic jalr,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic [31:0] epc,
                                input logic etk, input logic elv,
                                input logic [31:0] elink, input logic etrap,
                                input logic [31:0] ebrc, input logic [31:0] etkc);
        vec_t v;
        v.br = br; v.f3 = f3; v.jal = jal; v.jalr = jalr;
        v.rs1 = rs1; v.rs2 = rs2; v.imm = im;
        v.exp_pc = epc; v.exp_taken = etk; v.exp_lv = elv;
        v.exp_link = elink; v.exp_trap = etrap;
        v.exp_brc = ebrc; v.exp_tkc = etkc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic clear_instr();
        instr_valid = 1'b0; br_en = 1'b0; br_funct3 = 3'b000;
        jal_en = 1'b0; jalr_en = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b0;
        clear_instr();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_taken", {31'b0, taken}, 32'h0);
        chk("rst_link_valid", {31'b0, link_valid}, 32'h0);
        chk("rst_link_addr", link_addr, 32'h0);
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_br_count", br_count, 32'h0);
        chk("rst_taken_count", taken_count, 32'h0);
        chk("rst_br_count4", {28'b0, br_count4}, 32'h0);
        rst = 1'b0;
    endtask

    // Fetch handshake, then commit one instruction and check the result.
    task automatic exec_vec(input string name, input vec_t v);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            total++;
            $display("FAIL %s_fetch_timeout: actual imem_req=%b required=1", name, imem_req);
            return;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk({name, "_exec_req"}, {31'b0, imem_req}, 32'h0);
        instr_valid = 1'b1;
        br_en = v.br; br_funct3 = v.f3; jal_en = v.jal; jalr_en = v.jalr;
        rs1_data = v.rs1; rs2_data = v.rs2; imm = v.imm;
        @(negedge clk);
        clear_instr();
        chk({name, "_pc"}, pc, v.exp_pc);
        chk({name, "_taken"}, {31'b0, taken}, {31'b0, v.exp_taken});
        chk({name, "_link_valid"}, {31'b0, link_valid}, {31'b0, v.exp_lv});
        if (v.exp_lv) chk({name, "_link_addr"}, link_addr, v.exp_link);
        chk({name, "_trap"}, {31'b0, trap}, {31'b0, v.exp_trap});
        chk({name, "_imem_req"}, {31'b0, imem_req}, {31'b0, !v.exp_trap});
        chk({name, "_br_count"}, br_count, v.exp_brc);
        chk({name, "_taken_count"}, taken_count, v.exp_tkc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //              br  f3      jal  jalr rs1           rs2           imm           exp_pc        tk   lv   link          trap brc tkc
        vecs[0]  = mk(0, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        0, 0, 32'h0,   0, 0, 0);
        vecs[1]  = mk(0, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        0, 0, 32'h0,   0, 0, 0);
        vecs[2]  = mk(1, 3'b000, 0, 0, 32'd5,        32'd5,        32'd16,       32'd24,       1, 0, 32'h0,   0, 1, 1);
        vecs[3]  = mk(1, 3'b000, 0, 0, 32'd5,        32'd6,        32'd16,       32'd28,       0, 0, 32'h0,   0, 2, 1);
        vecs[4]  = mk(1, 3'b100, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd8,        32'd36,       1, 0, 32'h0,   0, 3, 2);
        vecs[5]  = mk(1, 3'b110, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd8,        32'd40,       0, 0, 32'h0,   0, 4, 2);
        vecs[6]  = mk(1, 3'b001, 0, 0, 32'd3,        32'd4,        32'hFFFFFFF8, 32'd32,       1, 0, 32'h0,   0, 5, 3);
        vecs[7]  = mk(1, 3'b101, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd12,       32'd44,       1, 0, 32'h0,   0, 6, 4);
        vecs[8]  = mk(1, 3'b111, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd12,       32'd48,       0, 0, 32'h0,   0, 7, 4);
        vecs[9]  = mk(1, 3'b010, 0, 0, 32'd7,        32'd7,        32'd8,        32'd52,       0, 0, 32'h0,   0, 8, 4);
        vecs[10] = mk(0, 3'b000, 1, 0, 32'h0,        32'h0,        32'd12,       32'h40,       1, 1, 32'd56,  0, 8, 4);
        vecs[11] = mk(1, 3'b000, 1, 1, 32'h100,      32'h100,      32'd1,        32'h100,      1, 1, 32'h44,  0, 8, 4);
        vecs[12] = mk(1, 3'b000, 1, 0, 32'h100,      32'h100,      32'hFFFFFF00, 32'h0,        1, 1, 32'h104, 0, 8, 4);
        vecs[13] = mk(0, 3'b000, 1, 0, 32'h0,        32'h0,        32'h40,       32'h40,       1, 1, 32'h4,   0, 8, 4);
        vecs[14] = mk(0, 3'b000, 0, 1, 32'h101,      32'h0,        32'd2,        32'h40,       0, 0, 32'h0,   1, 8, 4);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            exec_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Trap is sticky: pc frozen, no fetch, even with ready offered
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        chk("trap_hold_pc", pc, 32'h40);
        chk("trap_hold_flag", {31'b0, trap}, 32'h1);
        chk("trap_hold_req", {31'b0, imem_req}, 32'h0);

        // Stall beats imem_ready in FETCH
        do_reset();
        @(negedge clk);
        stall = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_pc_%0d", i), pc, 32'h0);
            chk($sformatf("stall_req_%0d", i), {31'b0, imem_req}, 32'h1);
        end
        stall = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("stall_release_exec", {31'b0, imem_req}, 32'h0);
        // Commit a taken beq so counters are nonzero before reset test
        instr_valid = 1'b1; br_en = 1'b1; br_funct3 = 3'b000;
        rs1_data = 32'd1; rs2_data = 32'd1; imm = 32'd8;
        @(negedge clk);
        clear_instr();
        chk("pre_rst_pc", pc, 32'h8);
        chk("pre_rst_br_count", br_count, 32'h1);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        // Reset in EXEC together with a valid taken branch
        rst = 1'b1; instr_valid = 1'b1; br_en = 1'b1; br_funct3 = 3'b000;
        rs1_data = 32'd1; rs2_data = 32'd1; imm = 32'd16;
        @(negedge clk);
        chk("rst_exec_pc", pc, 32'h0);
        chk("rst_exec_taken", {31'b0, taken}, 32'h0);
        chk("rst_exec_br_count", br_count, 32'h0);
        chk("rst_exec_taken_count", taken_count, 32'h0);
        chk("rst_exec_req", {31'b0, imem_req}, 32'h0);
        rst = 1'b0;
        clear_instr();

        // PC wrap: jal imm=-8 at pc=4
        do_reset();
        exec_vec("wrap_seq", mk(0, 3'b000, 0, 0, 32'h0, 32'h0, 32'h0, 32'h4, 0, 0, 32'h0, 0, 0, 0));
        exec_vec("wrap_jal", mk(0, 3'b000, 1, 0, 32'h0, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFC, 1, 1, 32'h8, 0, 0, 0));

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            exec_vec($sformatf("sat%0d", i),
                     mk(1, 3'b000, 0, 0, 32'd1, 32'd1, 32'd4, 32'(4 * (i + 1)),
                        1, 0, 32'h0, 0, 32'(i + 1), 32'(i + 1)));
        end
        chk("sat_br_count4", {28'b0, br_count4}, 32'd15);
        chk("sat_taken_count4", {28'b0, taken_count4}, 32'd15);
        chk("sat_pc4", pc4, 32'd80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
